// File: rtl/axi_lite_led_bram_responder.sv
// AXI4-Lite responder: LED register, ID register and scratch RAM.
// Independent write/read FSMs, one write and one read outstanding.
module axi_lite_led_bram_responder #(
  parameter int          ADDR_W        = 16,
  parameter int          SCRATCH_WORDS = 16,
  parameter logic [31:0] ID_VALUE      = 32'h4D50_5301,
  parameter logic [7:0]  LED_RESET     = 8'h00
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [7:0]        app_leds
);

  localparam int AW = ADDR_W - 2;
  localparam int SA = $clog2(SCRATCH_WORDS);
  localparam logic [AW-1:0] SCR_W = AW'(32'h400);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    A_LED, A_TGL, A_ID, A_SCR, A_BAD
  } area_t;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  function automatic area_t decode(
    input logic [AW-1:0] wa
  );
    area_t r;
    r = A_BAD;
    unique case (1'b1)
      (wa == AW'(0)): r = A_LED;
      (wa == AW'(1)): r = A_TGL;
      (wa == AW'(2)): r = A_ID;
      (wa[AW-1:SA] == SCR_W[AW-1:SA]):
        r = A_SCR;
      default: r = A_BAD;
    endcase
    return r;
  endfunction

  w_state_t w_q, w_d;
  r_state_t r_q, r_d;

  logic          up_q;
  logic          aw_held_q, w_held_q;
  logic [AW-1:0] aw_wa_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    bresp_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [7:0]    led_q;
  logic [31:0]   mem [SCRATCH_WORDS];

  logic        aw_hs, w_hs, ar_hs, commit;
  area_t       wr_area, rd_area;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;

  logic unused_lsb;
  assign unused_lsb = ^{S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = up_q && (w_q == W_IDLE)
                         && !aw_held_q;
  assign S_AXI_WREADY  = up_q && (w_q == W_IDLE)
                         && !w_held_q;
  assign S_AXI_ARREADY = up_q && (r_q == R_IDLE);
  assign S_AXI_BVALID  = (w_q == W_RESP);
  assign S_AXI_RVALID  = (r_q == R_DATA);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign app_leds      = led_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (w_q == W_IDLE)
                  && aw_held_q && w_held_q;

  assign wr_area = decode(aw_wa_q);
  assign rd_area = decode(S_AXI_ARADDR[ADDR_W-1:2]);

  always_comb begin
    wr_resp = OKAY;
    unique case (wr_area)
      A_ID:    wr_resp = SLVERR;
      A_BAD:   wr_resp = DECERR;
      default: wr_resp = OKAY;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    unique case (rd_area)
      A_LED:   rd_data = {24'h0, led_q};
      A_TGL:   rd_data = '0;
      A_ID:    rd_data = ID_VALUE;
      A_SCR:   rd_data = mem[S_AXI_ARADDR[SA+1:2]];
      default: rd_resp = DECERR;
    endcase
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (commit) w_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    unique case (r_q)
      R_IDLE: if (ar_hs) r_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      up_q      <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_wa_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      led_q     <= LED_RESET;
    end else begin
      up_q <= 1'b1;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_wa_q   <= S_AXI_AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_resp;
        if (wstrb_q[0]) begin
          if (wr_area == A_LED)
            led_q <= wdata_q[7:0];
          else if (wr_area == A_TGL)
            led_q <= led_q ^ wdata_q[7:0];
        end
      end
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  // RAM is deliberately not reset; commit is already gated by reset.
  always_ff @(posedge ACLK) begin
    if (commit && wr_area == A_SCR) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b])
          mem[aw_wa_q[SA-1:0]][8*b +: 8]
            <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/axi_lite_led_bram_responder.md
Name: axi_lite_led_bram_responder

Overview:
- AXI4-Lite slave (responder) on the PL side of the MPSoC base design; it is the target of PS GP-port single-beat write_data/read_data transactions.
- Presents an 8-bit LED output register, an ID register and a 16-word scratch RAM behind one address window.
- Independent write and read channel state machines. Every handshake follows AXI4-Lite rules. Error responses are returned for unmapped and read-only accesses.

Parameters:
- ADDR_W, 16, AXI address width (byte address; bits above ADDR_W ignored by the interconnect)
- SCRATCH_WORDS, 16, scratch RAM depth in 32-bit words (power of two, 2..64)
- ID_VALUE, 32'h4D50_5301, constant returned by the ID register
- LED_RESET, 8'h00, LED register reset value

Ports:
- ACLK  in  1  single clock for all logic
- ARESETn  in  1  asynchronous assert, active-low reset
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_W / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- app_leds  out  8  LED register contents

Behaviour:
- Address map (byte offsets, decoded on ADDR_W bits, bits [1:0] ignored):
  - 0x0000 LED_DATA RW, bits[7:0]; read returns {24'h0, led}.
  - 0x0004 LED_TOGGLE WO; led ^= WDATA[7:0] when WSTRB[0]; reads as 0, RESP OKAY.
  - 0x0008 ID RO; a write returns SLVERR with no effect.
  - 0x1000 .. 0x1000+4*SCRATCH_WORDS-1: scratch RW with per-byte WSTRB.
  - Anything else: DECERR (2'b11); reads return 32'h0, writes have no effect.
- Reset (async assert, synchronous deassert handled at top level):
  - AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, app_leds=LED_RESET.
  - Scratch contents are not reset.
  - From the first cycle after ARESETn high: AWREADY=WREADY=ARREADY=1.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY is high until AW is captured and WREADY is high until W is captured. AW and W are accepted in either order or in the same cycle; each is latched on its handshake and its READY drops once captured.
  - The cycle after both are held, the write commits and the FSM enters W_RESP with BVALID=1 and BRESP set. This is the same edge on which the commit happens.
  - W_RESP holds BVALID and BRESP stable until BREADY. On the BVALID&BREADY edge it returns to W_IDLE with both READYs high again. At most one write is outstanding.
  - LED_DATA write honours WSTRB[0] only. WSTRB=0 is legal: no data change, OKAY.
- Read FSM, states R_IDLE, R_DATA:
  - ARREADY=1 in R_IDLE. On the AR handshake, RDATA/RRESP are registered and RVALID=1 on the next edge (1-cycle latency). ARREADY=0 while in R_DATA.
  - RDATA/RRESP are held stable until RREADY, then the FSM returns to R_IDLE.
- Simultaneous read and write:
  - Both channels proceed concurrently.
  - If the read capture and the write commit hit the same location on the same edge, the read returns the old value (read-before-write).
- app_leds changes on the commit edge of a LED_DATA/LED_TOGGLE write.
- Reset mid-transaction: all VALID/READY and FSMs return to reset values immediately. The in-flight write is discarded unless already committed.

Test Plan:
- Reset then write 0x0000 data 32'hFFFFFFFF strobe 4'hF -> BRESP=OKAY, app_leds=8'hFF one edge after both AW/W captured; read 0x0000 -> RDATA=32'h000000FF, OKAY.
- Write 0x1000 32'hDEADBEEF, read back -> 32'hDEADBEEF. Write 0x1000 32'h00000011 strobe 4'b0001, read -> 32'hDEADBE11.
- W presented 3 cycles before AW, BREADY held low 5 cycles -> WREADY drops after W handshake, single commit, BVALID/BRESP stable all 5 cycles, exactly one response.
- Write ID 0x0008 -> SLVERR and ID unchanged (read -> ID_VALUE). Read 0x2000 -> DECERR, RDATA=0. Write 0x2000 -> DECERR.
- LED_DATA=8'hA5, write LED_TOGGLE 8'h0F -> app_leds=8'hAA. Concurrent read of 0x1004 and write of 0x1004 with 32'h1234 committing on the same edge -> read returns old value, later read returns 32'h00001234.
- ARESETn pulsed low while RVALID=1 and RREADY=0 -> RVALID=0, app_leds=LED_RESET immediately; the next read completes normally.
